// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : Registered multi-cycle ALU with start/busy/done handshake,
//               serial one-bit-per-cycle shifter and optional shift-add MUL
//               (enabled by defining ALU_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALU_op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             funct7b0,
  input  logic             opcode_b5,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] C_CNT_LAST = SHAMT_W'(WIDTH - 1);
  localparam logic [SHAMT_W-1:0] C_CNT_ONE  = SHAMT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef ALU_MUL_EN
    S_MUL,
`endif
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } op_e;

  state_e             r_state, w_state_n;
  op_e                r_op, w_op_n, w_op;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_n;
  logic [WIDTH-1:0]   r_work, w_work_n;
  logic [WIDTH-1:0]   w_result_n, w_alu, w_shifted;
  logic               w_illegal_n, w_busy_n, w_done_n, w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   r_acc, w_acc_n, r_mplier, w_mplier_n, w_acc_step;
`else
  logic               w_unused_funct7b0;
  assign w_unused_funct7b0 = funct7b0;
`endif

  assign w_shamt    = operand_b[SHAMT_W-1:0];
  assign w_is_shift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);

  always_comb begin
    w_op = OP_ILL;
    if (!ALU_op[1]) begin
      if (!ALU_op[0]) begin
        w_op = OP_ADD;
      end else begin
        case (funct3)
          3'b000, 3'b001: w_op = OP_SUB;
          3'b100, 3'b101: w_op = OP_SLT;
          3'b110, 3'b111: w_op = OP_SLTU;
          default:        w_op = OP_ILL;
        endcase
      end
    end else begin
      case (funct3)
        3'b000:  w_op = (funct7b5 & opcode_b5) ? OP_SUB : OP_ADD;
        3'b001:  w_op = OP_SLL;
        3'b010:  w_op = OP_SLT;
        3'b011:  w_op = OP_SLTU;
        3'b100:  w_op = OP_XOR;
        3'b101:  w_op = funct7b5 ? OP_SRA : OP_SRL;
        3'b110:  w_op = OP_OR;
        default: w_op = OP_AND;
      endcase
`ifdef ALU_MUL_EN
      // M-extension row overrides the base decode only for R-type
      if (opcode_b5 && funct7b0)
        w_op = (funct3 == 3'b000) ? OP_MUL : OP_ILL;
`endif
    end
  end

  // Single-cycle result; shifts land here only when shamt is zero
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = operand_a + operand_b;
      OP_SUB:  w_alu = operand_a - operand_b;
      OP_SLT:  w_alu = WIDTH'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: w_alu = WIDTH'(operand_a < operand_b);
      OP_XOR:  w_alu = operand_a ^ operand_b;
      OP_OR:   w_alu = operand_a | operand_b;
      OP_AND:  w_alu = operand_a & operand_b;
      OP_SLL, OP_SRL, OP_SRA: w_alu = operand_a;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    case (r_op)
      OP_SLL:  w_shifted = {r_work[WIDTH-2:0], 1'b0};
      OP_SRA:  w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_shifted = {1'b0, r_work[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_MUL_EN
  assign w_acc_step = r_acc + (r_mplier[0] ? r_work : '0);
`endif

  always_comb begin
    w_state_n   = r_state;
    w_op_n      = r_op;
    w_cnt_n     = r_cnt;
    w_work_n    = r_work;
    w_result_n  = result;
    w_illegal_n = illegal;
    w_busy_n    = busy;
    w_done_n    = 1'b0;
`ifdef ALU_MUL_EN
    w_acc_n     = r_acc;
    w_mplier_n  = r_mplier;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_n = 1'b1;
          w_op_n   = w_op;
          if (w_is_shift && (w_shamt != '0)) begin
            w_state_n = S_SHIFT;
            w_cnt_n   = w_shamt;
            w_work_n  = operand_a;
          end
`ifdef ALU_MUL_EN
          else if (w_op == OP_MUL) begin
            w_state_n  = S_MUL;
            w_cnt_n    = C_CNT_LAST;
            w_work_n   = operand_a;
            w_acc_n    = '0;
            w_mplier_n = operand_b;
          end
`endif
          else begin
            w_state_n   = S_DONE;
            w_done_n    = 1'b1;
            w_result_n  = w_alu;
            w_illegal_n = (w_op == OP_ILL);
          end
        end
      end
      // The last shift step retires straight into DONE to keep latency shamt+1
      S_SHIFT: begin
        w_work_n = w_shifted;
        w_cnt_n  = r_cnt - C_CNT_ONE;
        if (r_cnt == C_CNT_ONE) begin
          w_state_n   = S_DONE;
          w_done_n    = 1'b1;
          w_result_n  = w_shifted;
          w_illegal_n = 1'b0;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        w_acc_n    = w_acc_step;
        w_work_n   = {r_work[WIDTH-2:0], 1'b0};
        w_mplier_n = {1'b0, r_mplier[WIDTH-1:1]};
        if (r_cnt == '0) begin
          w_state_n   = S_DONE;
          w_done_n    = 1'b1;
          w_result_n  = w_acc_step;
          w_illegal_n = 1'b0;
        end else begin
          w_cnt_n = r_cnt - C_CNT_ONE;
        end
      end
`endif
      S_DONE: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end
      default: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      result  <= '0;
      zero    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      r_state <= w_state_n;
      result  <= w_result_n;
      zero    <= (w_result_n == '0);
      busy    <= w_busy_n;
      done    <= w_done_n;
      illegal <= w_illegal_n;
    end
  end

  always_ff @(posedge clock) begin
    r_op   <= w_op_n;
    r_cnt  <= w_cnt_n;
    r_work <= w_work_n;
`ifdef ALU_MUL_EN
    r_acc    <= w_acc_n;
    r_mplier <= w_mplier_n;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_multicycle
// Description : Self-checking bench for alu_multicycle (honours ALU_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  logic        clock = 1'b0;
  logic        reset, start, funct7b5, funct7b0, opcode_b5;
  logic [1:0]  ALU_op;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b, result;
  logic        zero, busy, done, illegal;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .ALU_op(ALU_op),
    .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .opcode_b5(opcode_b5), .operand_a(operand_a), .operand_b(operand_b),
    .result(result), .zero(zero), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  alu_op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        f7b0;
    logic        opb5;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

`ifdef ALU_MUL_EN
  localparam logic [31:0] MUL_RES = 32'hFFFF_FFFD;
  localparam int          MUL_LAT = 33;
  localparam logic [31:0] M1_RES  = 32'h0;
  localparam logic        M1_ILL  = 1'b1;
  localparam int          M1_LAT  = 1;
`else
  localparam logic [31:0] MUL_RES = 32'h2;
  localparam int          MUL_LAT = 1;
  localparam logic [31:0] M1_RES  = 32'h4;
  localparam logic        M1_ILL  = 1'b0;
  localparam int          M1_LAT  = 3;
`endif

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                       input logic f7b0, input logic opb5, input logic [31:0] a,
                       input logic [31:0] b);
    ALU_op = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0;
    opcode_b5 = opb5; operand_a = a; operand_b = b;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int   lat;
    logic busy_ok;
    @(negedge clock);
    drive(v.alu_op, v.f3, v.f7b5, v.f7b0, v.opb5, v.a, v.b);
    start = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 64) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d busy", idx), {31'b0, busy_ok}, 32'd1);
    chk($sformatf("v%0d result", idx), result, v.res);
    chk($sformatf("v%0d zero", idx), {31'b0, zero}, {31'b0, (v.res == 32'd0)});
    chk($sformatf("v%0d illegal", idx), {31'b0, illegal}, {31'b0, v.ill});
    @(negedge clock);
    chk($sformatf("v%0d idle", idx), {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    //           op    f3    f7b5  f7b0  opb5  a              b              res            ill   lat
    vecs[0]  = '{2'd2, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1};
    vecs[1]  = '{2'd1, 3'd6, 1'b0, 1'b0, 1'b1, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1};
    vecs[2]  = '{2'd0, 3'd5, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1};
    vecs[3]  = '{2'd1, 3'd4, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1};
    vecs[4]  = '{2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 32'd10,        32'd3,         32'd7,         1'b0, 1};
    vecs[5]  = '{2'd1, 3'd2, 1'b0, 1'b0, 1'b1, 32'd9,         32'd4,         32'd0,         1'b1, 1};
    vecs[6]  = '{2'd2, 3'd0, 1'b1, 1'b0, 1'b0, 32'd5,         32'd7,         32'd12,        1'b0, 1};
    vecs[7]  = '{2'd2, 3'd4, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1};
    vecs[8]  = '{2'd3, 3'd6, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1};
    vecs[9]  = '{2'd2, 3'd7, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1};
    vecs[10] = '{2'd3, 3'd2, 1'b0, 1'b0, 1'b1, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1};
    vecs[11] = '{2'd2, 3'd3, 1'b0, 1'b0, 1'b1, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1};
    vecs[12] = '{2'd2, 3'd5, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 5};
    vecs[13] = '{2'd2, 3'd1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1};
    vecs[14] = '{2'd2, 3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 32};
    vecs[15] = '{2'd2, 3'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3,         MUL_RES,       1'b0, MUL_LAT};
    vecs[16] = '{2'd2, 3'd1, 1'b0, 1'b1, 1'b1, 32'd1,         32'd2,         M1_RES,        M1_ILL, M1_LAT};

    reset = 1'b1; start = 1'b0;
    drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clock);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'b0, zero}, 32'd1);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset illegal", {31'b0, illegal}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_op(vecs[i], i);

    // start held high through a shift, then into the DONE cycle, then idle
    @(negedge clock);
    drive(2'd2, 3'd5, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4);
    start = 1'b1;
    @(negedge clock);
    drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
    ndone = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clock);
      if (done) ndone++;
      chk($sformatf("hs busy c%0d", k), {31'b0, busy}, 32'd1);
    end
    chk("hs done at E0+5", {31'b0, done}, 32'd1);
    chk("hs result", result, 32'hF800_0000);
    chk("hs done count", ndone, 32'd1);
    @(negedge clock);
    chk("hs start in DONE ignored", {30'b0, busy, done}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    chk("hs next accept done", {31'b0, done}, 32'd1);
    chk("hs next accept result", result, 32'd2);
    @(negedge clock);
    chk("hs idle after", {30'b0, busy, done}, 32'd0);

    // reset during the third shift cycle of a 20-bit shift
    @(negedge clock);
    drive(2'd2, 3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd20);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid reset busy", {31'b0, busy}, 32'd0);
    chk("mid reset done", {31'b0, done}, 32'd0);
    chk("mid reset result", result, 32'd0);
    chk("mid reset zero", {31'b0, zero}, 32'd1);
    reset = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    chk("mid reset no done", ndone, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
